// File: rtl/sprite_mover.sv
// Sprite top-left position generator with a programmable tick divider and variable step.
// Supports manual wrap, manual clamp, autonomous bounce and hold, plus edge-hit pulses and a hit counter.
module sprite_mover #(
  parameter int HOR_FIELD = 800,
  parameter int VER_FIELD = 600,
  parameter int SIZE      = 25,
  parameter int HOR_W     = 12,
  parameter int VER_W     = 11,
  parameter int TICK_DIV  = 1048576,
  parameter int INIT_HOR  = 0,
  parameter int INIT_VER  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       control,
  input  logic [1:0]       mode,
  input  logic [3:0]       speed,
  output logic [HOR_W-1:0] hor_pos,
  output logic [VER_W-1:0] ver_pos,
  output logic             tick,
  output logic             hit_h,
  output logic             hit_v,
  output logic [15:0]      bounce_count
);

  localparam int CNT_W = $clog2(TICK_DIV);
  // One shared signed width, two bits wider than the widest axis, catches both underflow and overflow.
  localparam int W = ((HOR_W > VER_W) ? HOR_W : VER_W) + 2;

  typedef logic signed [W-1:0] coord_t;

  localparam coord_t HMAX = coord_t'(HOR_FIELD - SIZE);
  localparam coord_t VMAX = coord_t'(VER_FIELD - SIZE);
  localparam coord_t ZERO = '0;

  typedef enum logic [1:0] {
    MODE_WRAP   = 2'b00,
    MODE_CLAMP  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef struct packed {
    coord_t pos;
    logic   hit;
    logic   flip;
  } axis_t;

  function automatic axis_t step_axis(input coord_t pos, input coord_t lim, input logic [3:0] spd,
                                      input logic inc, input logic dec, input mode_e md,
                                      input logic fwd);
    coord_t delta;
    coord_t nxt;
    axis_t  res;
    delta    = {{(W-4){1'b0}}, spd};
    nxt      = pos;
    res.pos  = pos;
    res.hit  = 1'b0;
    res.flip = 1'b0;
    case (md)
      MODE_WRAP, MODE_CLAMP: begin
        if (inc && !dec)
          nxt = pos + delta;
        else if (dec && !inc)
          nxt = pos - delta;
        if (nxt < ZERO) begin
          res.pos = (md == MODE_WRAP) ? lim : ZERO;
          res.hit = (md == MODE_CLAMP);
        end else if (nxt > lim) begin
          res.pos = (md == MODE_WRAP) ? ZERO : lim;
          res.hit = (md == MODE_CLAMP);
        end else begin
          res.pos = nxt;
        end
      end
      MODE_BOUNCE: begin
        nxt = fwd ? (pos + delta) : (pos - delta);
        // Reflect the overshoot back into the field; landing exactly on an edge is not a contact.
        if (nxt > lim) begin
          res.pos  = lim + lim - nxt;
          res.hit  = 1'b1;
          res.flip = 1'b1;
        end else if (nxt < ZERO) begin
          res.pos  = ZERO - nxt;
          res.hit  = 1'b1;
          res.flip = 1'b1;
        end else begin
          res.pos = nxt;
        end
      end
      default: ;
    endcase
    return res;
  endfunction

  logic [CNT_W-1:0] div_count;
  logic             dx;
  logic             dy;
  logic             btn_up;
  logic             btn_down;
  logic             btn_left;
  logic             btn_right;
  axis_t            hor_step;
  axis_t            ver_step;
  logic             unused_bits;

  assign btn_up    = ~control[3];
  assign btn_down  = ~control[0];
  assign btn_left  = ~control[1];
  assign btn_right = ~control[2];

  always_comb begin
    hor_step = step_axis(coord_t'({{(W-HOR_W){1'b0}}, hor_pos}), HMAX, speed,
                         btn_right, btn_left, mode_e'(mode), dx);
    ver_step = step_axis(coord_t'({{(W-VER_W){1'b0}}, ver_pos}), VMAX, speed,
                         btn_down, btn_up, mode_e'(mode), dy);
  end

  assign unused_bits = ^{hor_step.pos[W-1:HOR_W], ver_step.pos[W-1:VER_W]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_count <= '0;
      tick      <= 1'b0;
    end else if (div_count == CNT_W'(TICK_DIV - 1)) begin
      div_count <= '0;
      tick      <= 1'b1;
    end else begin
      div_count <= div_count + CNT_W'(1);
      tick      <= 1'b0;
    end
  end

  // Motion state only advances on the edge where the divider strobe is high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hor_pos      <= HOR_W'(INIT_HOR);
      ver_pos      <= VER_W'(INIT_VER);
      hit_h        <= 1'b0;
      hit_v        <= 1'b0;
      dx           <= 1'b1;
      dy           <= 1'b1;
      bounce_count <= '0;
    end else begin
      hit_h <= 1'b0;
      hit_v <= 1'b0;
      if (tick) begin
        hor_pos <= hor_step.pos[HOR_W-1:0];
        ver_pos <= ver_step.pos[VER_W-1:0];
        hit_h   <= hor_step.hit;
        hit_v   <= ver_step.hit;
        if (hor_step.flip)
          dx <= ~dx;
        if (ver_step.flip)
          dy <= ~dy;
        if ((hor_step.hit || ver_step.hit) && (bounce_count != 16'hFFFF))
          bounce_count <= bounce_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: stimulus pushes model results on each tick, a monitor
// pops and compares them in the update cycle and checks tick timing and hold behaviour otherwise.
module tb_sprite_mover;

  localparam int HOR_FIELD = 40;
  localparam int VER_FIELD = 30;
  localparam int SIZE      = 8;
  localparam int HOR_W     = 12;
  localparam int VER_W     = 11;
  localparam int TICK_DIV  = 4;
  localparam int INIT_HOR  = 0;
  localparam int INIT_VER  = 0;
  localparam int HMAX      = HOR_FIELD - SIZE;
  localparam int VMAX      = VER_FIELD - SIZE;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [3:0]       control = 4'hF;
  logic [1:0]       mode = 2'b00;
  logic [3:0]       speed = 4'd0;
  logic [HOR_W-1:0] hor_pos;
  logic [VER_W-1:0] ver_pos;
  logic             tick;
  logic             hit_h;
  logic             hit_v;
  logic [15:0]      bounce_count;

  sprite_mover #(
    .HOR_FIELD(HOR_FIELD), .VER_FIELD(VER_FIELD), .SIZE(SIZE), .HOR_W(HOR_W), .VER_W(VER_W),
    .TICK_DIV(TICK_DIV), .INIT_HOR(INIT_HOR), .INIT_VER(INIT_VER)
  ) dut (
    .clock(clock), .reset(reset), .control(control), .mode(mode), .speed(speed),
    .hor_pos(hor_pos), .ver_pos(ver_pos), .tick(tick), .hit_h(hit_h), .hit_v(hit_v),
    .bounce_count(bounce_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int hor;
    int ver;
    bit hh;
    bit hv;
    int cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  int   mHor, mVer, mDx, mDy, mCnt;
  int   edgeCount = 0;
  int   nChecks = 0;
  int   nFails = 0;
  bit   done = 1'b0;

  // Rising edges since reset release; ticks are expected at every TICK_DIV-th edge.
  always @(posedge clock or negedge reset)
    if (!reset) edgeCount <= 0;
    else        edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mHor = INIT_HOR;
    mVer = INIT_VER;
    mDx  = 1;
    mDy  = 1;
    mCnt = 0;
    cur  = '{hor: INIT_HOR, ver: INIT_VER, hh: 1'b0, hv: 1'b0, cnt: 0};
    expQ.delete();
  endtask

  task automatic moveManual(inout int pos, input int delta, input int lim, input bit clamp,
                            output bit hit);
    int n;
    n   = pos + delta;
    hit = 1'b0;
    if (n < 0) begin
      pos = clamp ? 0 : lim;
      hit = clamp;
    end else if (n > lim) begin
      pos = clamp ? lim : 0;
      hit = clamp;
    end else begin
      pos = n;
    end
  endtask

  task automatic moveBounce(inout int pos, inout int dir, input int spd, input int lim,
                            output bit hit);
    int n;
    n   = pos + dir * spd;
    hit = 1'b0;
    if (n > lim) begin
      pos = 2 * lim - n;
      dir = -dir;
      hit = 1'b1;
    end else if (n < 0) begin
      pos = -n;
      dir = -dir;
      hit = 1'b1;
    end else begin
      pos = n;
    end
  endtask

  task automatic modelStep(input logic [3:0] ctrl, input int md, input int spd,
                           output bit hh, output bit hv);
    int rh;
    int rv;
    rh = (ctrl[2] ? 0 : 1) - (ctrl[1] ? 0 : 1);
    rv = (ctrl[0] ? 0 : 1) - (ctrl[3] ? 0 : 1);
    hh = 1'b0;
    hv = 1'b0;
    case (md)
      0, 1: begin
        moveManual(mHor, rh * spd, HMAX, md == 1, hh);
        moveManual(mVer, rv * spd, VMAX, md == 1, hv);
      end
      2: begin
        moveBounce(mHor, mDx, spd, HMAX, hh);
        moveBounce(mVer, mDy, spd, VMAX, hv);
      end
      default: ;
    endcase
    if ((hh || hv) && mCnt < 65535) mCnt++;
  endtask

  // Waits for the tick cycle, drives inputs sampled on the update edge, queues the model result.
  task automatic applyStimulus(input logic [3:0] ctrl, input int md, input int spd);
    int waited;
    bit hh;
    bit hv;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!(reset && edgeCount > 0 && edgeCount % TICK_DIV == 0) && waited < 4 * TICK_DIV);
    if (!(reset && edgeCount > 0 && edgeCount % TICK_DIV == 0)) begin
      checkOutput("tick wait", 0, 1);
      return;
    end
    control = ctrl;
    mode    = 2'(md);
    speed   = 4'(spd);
    modelStep(ctrl, md, spd, hh, hv);
    expQ.push_back('{hor: mHor, ver: mVer, hh: hh, hv: hv, cnt: mCnt});
  endtask

  task automatic randomStimulus(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 15)));
  endtask

  // Monitor: update cycles are popped from the scoreboard, other cycles must hold state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done) break;
      if (reset) begin
        checkOutput("tick", int'(tick), (edgeCount > 0 && edgeCount % TICK_DIV == 0) ? 1 : 0);
        if (edgeCount > TICK_DIV && edgeCount % TICK_DIV == 1) begin
          if (expQ.size() == 0) begin
            checkOutput("scoreboard empty", 0, 1);
          end else begin
            e   = expQ.pop_front();
            cur = e;
            checkOutput("hor_pos", int'(hor_pos), e.hor);
            checkOutput("ver_pos", int'(ver_pos), e.ver);
            checkOutput("hit_h", int'(hit_h), int'(e.hh));
            checkOutput("hit_v", int'(hit_v), int'(e.hv));
            checkOutput("bounce_count", int'(bounce_count), e.cnt);
          end
        end else begin
          checkOutput("hold hor_pos", int'(hor_pos), cur.hor);
          checkOutput("hold ver_pos", int'(ver_pos), cur.ver);
          checkOutput("idle hits", int'({hit_h, hit_v}), 0);
          checkOutput("hold bounce_count", int'(bounce_count), cur.cnt);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset hor_pos", int'(hor_pos), INIT_HOR);
    checkOutput("reset ver_pos", int'(ver_pos), INIT_VER);
    checkOutput("reset tick", int'(tick), 0);
    checkOutput("reset hits", int'({hit_h, hit_v}), 0);
    checkOutput("reset bounce_count", int'(bounce_count), 0);
    @(negedge clock);
    reset = 1'b1;

    repeat (3) applyStimulus(4'hF, 0, 5);
    // Wrap: left past 0, then right past HMAX.
    applyStimulus(4'b1101, 0, 1);
    applyStimulus(4'b1101, 0, 1);
    applyStimulus(4'b1011, 0, 3);
    // Clamp: down into the bottom edge twice.
    applyStimulus(4'b1110, 0, 10);
    applyStimulus(4'b1110, 0, 10);
    applyStimulus(4'b1110, 1, 3);
    applyStimulus(4'b1110, 1, 3);
    // Bounce off the bottom to turn dy upward, then position for a corner hit.
    applyStimulus(4'hF, 2, 3);
    applyStimulus(4'b1011, 0, 15);
    applyStimulus(4'b1011, 0, 13);
    applyStimulus(4'b0111, 0, 15);
    applyStimulus(4'b0111, 0, 3);
    applyStimulus(4'hF, 2, 3);
    repeat (4) applyStimulus(4'($urandom_range(0, 15)), 2, 7);
    // Opposing buttons cancel; hold freezes everything.
    applyStimulus(4'b0110, 0, 5);
    applyStimulus(4'b0000, 1, 9);
    for (int i = 0; i < 10; i++)
      applyStimulus(4'($urandom_range(0, 15)), 3, int'($urandom_range(0, 15)));
    randomStimulus(60);

    // Steer to hor_pos 17, then assert reset between clock edges.
    repeat (3) applyStimulus(4'b1101, 1, 15);
    applyStimulus(4'b1011, 1, 15);
    applyStimulus(4'b1011, 1, 2);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async hor_pos", int'(hor_pos), INIT_HOR);
    checkOutput("async ver_pos", int'(ver_pos), INIT_VER);
    checkOutput("async tick", int'(tick), 0);
    checkOutput("async hits", int'({hit_h, hit_v}), 0);
    checkOutput("async bounce_count", int'(bounce_count), 0);
    modelReset();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    repeat (3) applyStimulus(4'hF, 2, 11);
    randomStimulus(10);
    @(negedge clock);
    #1;
    done = 1'b1;
    @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Parametrised successor of the button-driven sprite position generator, feeding the VGA sprite renderer with the top-left corner (hor_pos, ver_pos) of a SIZE x SIZE square.
- Adds a programmable tick divider and a variable step size.
- Adds three motion modes: manual wrap, manual clamp and autonomous bounce with reflection. A hold mode freezes the sprite.
- Emits edge-hit pulses and a saturating bounce counter for the score and sound logic.

Parameters:
- HOR_FIELD, 800, visible width in pixels.
- VER_FIELD, 600, visible height in pixels.
- SIZE, 25, sprite edge length in pixels.
- HOR_W, 12, width of hor_pos.
- VER_W, 11, width of ver_pos.
- TICK_DIV, 1048576, clock cycles per motion tick (≥2).
- INIT_HOR, 0, hor_pos after reset.
- INIT_VER, 0, ver_pos after reset.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- control  in  4  buttons, active-low: [3] up, [0] down, [1] left, [2] right.
- mode  in  2  00 wrap, 01 clamp, 10 bounce, 11 hold.
- speed  in  4  pixels moved per tick per axis. 0 means no motion.
- hor_pos  out  HOR_W  sprite x, range 0..HMAX where HMAX = HOR_FIELD-SIZE.
- ver_pos  out  VER_W  sprite y, range 0..VMAX where VMAX = VER_FIELD-SIZE.
- tick  out  1  one-cycle motion strobe.
- hit_h  out  1  one-cycle pulse: left or right edge contact on this tick.
- hit_v  out  1  one-cycle pulse: top or bottom edge contact on this tick.
- bounce_count  out  16  number of ticks with any hit, saturating at 16'hFFFF.

Behaviour:
- Reset (reset = 0, asynchronous) sets:
  - hor_pos = INIT_HOR, ver_pos = INIT_VER.
  - Divider counter = 0; tick, hit_h, hit_v = 0; bounce_count = 0.
  - Direction flags dx = 1 (right) and dy = 1 (down).
- INIT_HOR ≤ HMAX and INIT_VER ≤ VMAX. HMAX ≥ 15 and VMAX ≥ 15 so one step never skips the field.
- Divider:
  - The counter increments every cycle.
  - On the edge where the counter equals TICK_DIV-1: counter ← 0 and tick ← 1. Otherwise tick ← 0.
  - First tick is high during the cycle after TICK_DIV rising edges following reset release. Period is TICK_DIV cycles.
- Update:
  - On the rising edge where tick = 1, the position, hit flags and count update. They are visible one cycle after tick.
  - On all other edges hit_h and hit_v are 0 and the position holds.
- Arithmetic: each axis computes next = pos ± speed in a signed (W+2)-bit intermediate to detect underflow below 0 and overflow above MAX.
- Manual request (modes 00 and 01):
  - Per-axis request is (right − left) or (down − up). Screen y grows downward, so down increments ver_pos.
  - Opposing buttons pressed together cancel to 0 on that axis.
  - Axes are independent.
- Mode 00, wrap:
  - next < 0 → pos = MAX.
  - next > MAX → pos = 0.
  - Otherwise pos = next.
  - hit pulses stay 0.
- Mode 01, clamp:
  - next < 0 → pos = 0 and hit on that axis.
  - next > MAX → pos = MAX and hit on that axis.
  - A button held against an edge re-hits on every tick.
- Mode 10, bounce:
  - Buttons are ignored. Each axis moves by speed in direction dx / dy.
  - next > MAX → pos = 2*MAX − next, flip the flag, hit.
  - next < 0 → pos = −next, flip the flag, hit.
  - Landing exactly on 0 or MAX is not a hit and does not flip.
  - A corner hit sets both hit_h and hit_v.
  - The dx / dy flags persist across mode changes.
- Mode 11, hold: position and flags frozen, no hits. The divider keeps running.
- bounce_count increments by 1 on any update with hit_h or hit_v set; a corner counts once. It saturates and never wraps.
- Mode and speed are sampled only on tick edges. Changes between ticks take effect at the next tick.
- Reset asserted mid-operation clears everything immediately, including a pending tick. Timing restarts from counter 0.

Test Plan:
- Params: HOR_FIELD=40, VER_FIELD=30, SIZE=8 (HMAX=32, VMAX=22), TICK_DIV=4. Test 1: release reset → tick high only in the cycle after the 4th edge, then every 4 cycles; positions stay 0 with no buttons.
- Wrap: mode 00, speed 1, left held from hor_pos 0 → hor_pos 32 one cycle after the tick. Right held at 31 with speed 3 → 0. No hit_h.
- Clamp: mode 01, speed 3, down held from ver_pos 20 → 22 with hit_v; the next tick → 22 with hit_v again. bounce_count = 2.
- Bounce: mode 10, speed 3, hor_pos 31, dx right → 30, dx left, hit_h. With ver_pos 1 and dy up → 2, dy down, hit_v on the same tick. Both hits on that tick → bounce_count +1.
- Cancel and hold: up+down held in mode 00 → ver_pos unchanged. Mode 11 in any state → no change for 10 ticks, tick still toggling.
- Async reset: pull reset low mid-period while hor_pos = 17 → outputs return to INIT values without a clock edge. bounce_count = 0. The next tick comes 4 edges after release.
